m_muldiv_seq: RTL



---
 rtl/m_muldiv_seq_pkg.sv | 24 ++
 rtl/m_muldiv_itercnt.sv | 41 ++++
 rtl/m_muldiv_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/m_muldiv_seq_pkg.sv
// Shared constants for the iterative multiply/divide sequencer.
package m_muldiv_seq_pkg;

  // Default number of add/shift iteration pairs.
  localparam int unsigned NITER_DEF = 32;

  // Sequencer state encoding (binary).
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_ADD  = 3'd2;
  localparam logic [2:0] S_SHFT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // M-extension funct3 op codes; bit 2 separates DIV*/REM* from MUL*.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/m_muldiv_itercnt.sv
// Loadable down-counter of remaining iteration pairs, with zero flag.
module m_muldiv_itercnt #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic         clr_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] iter_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load, load beats decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign iter_o = cnt_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/m_muldiv_seq.sv
// Sequencer for the iterative multiply/divide datapath: schedules alternating
// add and shift cycles and drives the condition-flag controls.
module m_muldiv_seq
  import m_muldiv_seq_pkg::*;
#(
  parameter int unsigned MULDIV = 1,
  parameter int unsigned NITER  = NITER_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     flush,
  input  logic [2:0]               funct3,
  input  logic                     mbit,
  output logic                     ceM,
  output logic                     use_dinx,
  output logic                     cond_holdq,
  output logic                     addq,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NITER)-1:0] iter
);

  localparam int unsigned IW = $clog2(NITER);

  if (MULDIV != 0) begin : g_seq
    localparam logic [IW-1:0] IterInit = IW'(NITER - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] f3_q, f3_d;
    logic       isdiv;
    logic       cnt_load, cnt_dec, cnt_clr, cnt_last;
    logic       unused_f3;

    assign isdiv     = f3_q[2];
    // Only the op class steers the schedule; the low bits are kept for the datapath.
    assign unused_f3 = ^f3_q[1:0];

    m_muldiv_itercnt #(
      .W (IW)
    ) u_itercnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load),
      .dec_i      (cnt_dec),
      .clr_i      (cnt_clr),
      .load_val_i (IterInit),
      .iter_o     (iter),
      .last_o     (cnt_last)
    );

    // Next-state: MUL pairs are ADD,SHFT and DIV pairs are SHFT,ADD; the
    // pair ends on its second cycle, where the counter steps or we exit.
    always_comb begin
      state_d  = state_q;
      f3_d     = f3_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_clr  = 1'b0;
      if (flush) begin
        state_d = S_IDLE;
        cnt_clr = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_d  = S_INIT;
              f3_d     = funct3;
              cnt_load = 1'b1;
            end
          end
          S_INIT: state_d = isdiv ? S_SHFT : S_ADD;
          S_ADD: begin
            if (!isdiv) begin
              state_d = S_SHFT;
            end else if (cnt_last) begin
              state_d = S_DONE;
            end else begin
              state_d = S_SHFT;
              cnt_dec = 1'b1;
            end
          end
          S_SHFT: begin
            if (isdiv) begin
              state_d = S_ADD;
            end else if (cnt_last) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ADD;
              cnt_dec = 1'b1;
            end
          end
          S_DONE:  state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end

    // State and captured funct3.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        f3_q    <= 3'b000;
      end else begin
        state_q <= state_d;
        f3_q    <= f3_d;
      end
    end

    // Outputs decode from state; only addq/cond_holdq look at mbit in ADD.
    always_comb begin
      ceM        = (state_q == S_SHFT);
      use_dinx   = (state_q == S_INIT);
      busy       = (state_q == S_INIT) || (state_q == S_ADD) || (state_q == S_SHFT);
      done       = (state_q == S_DONE);
      addq       = 1'b0;
      cond_holdq = 1'b0;
      if (state_q == S_ADD) begin
        addq       = isdiv ? 1'b1 : mbit;
        // Pass-Q or a failed trial subtract must leave the sign flag alone.
        cond_holdq = ~mbit;
      end
    end
  end else begin : g_off
    logic unused_in;

    assign unused_in  = ^{clk, rst_n, start, flush, funct3, mbit};
    assign ceM        = 1'b0;
    assign use_dinx   = 1'b0;
    assign cond_holdq = 1'b0;
    assign addq       = 1'b0;
    assign busy       = 1'b0;
    assign done       = 1'b0;
    assign iter       = '0;
  end

endmodule
